fpga_cfg_loader: RTL

Configuration-stream transmitter for the CLB tile array. It accepts bitstream words on a valid/ready interface and serializes them into the per-column configuration shift chains (`shift_enable`, `shift_in_hard`). When every column is loaded, it pulses `set_hard` to all columns to commit the configuration. It runs in the configuration clock domain and drives the same column ports that the array's config chain receives.

---
 rtl/fpga_cfg_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: serializes valid/ready words into per-column config chains, then commits.
// Optional trailer-word XOR checksum enabled by defining CFG_LOADER_CHECKSUM_EN.
module fpga_cfg_loader #(
    parameter int NUM_COLS  = 2,
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 32
) (
    input  logic                cclk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [NUM_COLS-1:0] shift_enable,
    output logic [NUM_COLS-1:0] shift_in_hard,
    output logic [NUM_COLS-1:0] set_hard,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int WPC   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST  = CHAIN_LEN - (WPC - 1) * WORD_W;
    localparam int COL_W = $clog2(NUM_COLS) + 1;
    localparam int WRD_W = $clog2(WPC) + 1;
    localparam int BIT_W = $clog2(WORD_W) + 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, SHIFT, CHECK, COMMIT, DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [WRD_W-1:0]    word_reg, word_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic [BIT_W-1:0]    last_bit;
    logic [WORD_W-1:0]   sr_reg, sr_next;
    logic [NUM_COLS-1:0] col_sel;
    logic                in_ready_next, busy_next, done_next;

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   csum_reg, csum_next;
    logic                err_reg, err_next;
`endif

    // The final word of a column only carries the remaining chain bits.
    assign last_bit = (word_reg == WRD_W'(WPC - 1)) ? BIT_W'(LAST - 1) : BIT_W'(WORD_W - 1);

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        word_next  = word_reg;
        bit_next   = bit_reg;
        sr_next    = sr_reg;
`ifdef CFG_LOADER_CHECKSUM_EN
        csum_next  = csum_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    col_next   = '0;
                    word_next  = '0;
                    bit_next   = '0;
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_next  = '0;
                    err_next   = 1'b0;
`endif
                end
            end
            FETCH: begin
                if (in_valid && in_ready) begin
                    sr_next    = in_data;
                    bit_next   = '0;
                    state_next = SHIFT;
`ifdef CFG_LOADER_CHECKSUM_EN
                    csum_next  = csum_reg ^ in_data;
`endif
                end
            end
            SHIFT: begin
                sr_next  = sr_reg >> 1;
                bit_next = bit_reg + 1'b1;
                if (bit_reg == last_bit) begin
                    bit_next   = '0;
                    state_next = FETCH;
                    if (word_reg == WRD_W'(WPC - 1)) begin
                        word_next = '0;
                        if (col_reg == COL_W'(NUM_COLS - 1)) begin
`ifdef CFG_LOADER_CHECKSUM_EN
                            state_next = CHECK;
`else
                            state_next = COMMIT;
`endif
                        end else begin
                            col_next = col_reg + 1'b1;
                        end
                    end else begin
                        word_next = word_reg + 1'b1;
                    end
                end
            end
            CHECK: begin
`ifdef CFG_LOADER_CHECKSUM_EN
                if (in_valid && in_ready) begin
                    if (in_data == csum_reg) begin
                        state_next = COMMIT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
`else
                state_next = IDLE;
`endif
            end
            COMMIT:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // Outputs are registered as a function of the next state so they line up with it.
    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
            assign col_sel[gi] = (state_next == SHIFT) && (col_next == COL_W'(gi));
        end
    endgenerate

    assign in_ready_next = (state_next == FETCH) || (state_next == CHECK);
    assign busy_next     = (state_next != IDLE) && (state_next != DONE);
    assign done_next     = (state_next == DONE);

    always_ff @(posedge cclk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            col_reg       <= '0;
            word_reg      <= '0;
            bit_reg       <= '0;
            sr_reg        <= '0;
            in_ready      <= 1'b0;
            shift_enable  <= '0;
            shift_in_hard <= '0;
            set_hard      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            word_reg      <= word_next;
            bit_reg       <= bit_next;
            sr_reg        <= sr_next;
            in_ready      <= in_ready_next;
            shift_enable  <= col_sel;
            shift_in_hard <= col_sel & {NUM_COLS{sr_next[0]}};
            set_hard      <= {NUM_COLS{state_next == COMMIT}};
            busy          <= busy_next;
            done          <= done_next;
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    always_ff @(posedge cclk or negedge rst) begin
        if (!rst) begin
            csum_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            csum_reg <= csum_next;
            err_reg  <= err_next;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule
